// File: rtl/cla_multiword_seq_pkg.sv
// Shared definitions for the multi-word CLA sequencer: limb width, FSM states
// and the limb-index width helper.
package cla_seq_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Smallest width able to count 0..words-1, never narrower than one bit.
  function automatic int idx_width(input int words);
    int w;
    w = 1;
    while ((1 << w) < words) w++;
    return w;
  endfunction

endpackage

// File: rtl/cla_multiword_seq_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead unit
// producing the group carries directly from cin.
module CLA_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g, p, c;
  logic [3:0]  gg, pg;
  logic [4:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    // Group carries are flattened sums of products, not a ripple chain.
    gc[0] = cin;
    gc[1] = gg[0] | (pg[0] & cin);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// WORDS x 16-bit add/subtract sequencer: one shared 16-bit CLA processes one
// limb per cycle, LSB first, with valid/ready on both sides.
module cla_multiword_seq
  import cla_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LIMB_W*WORDS-1:0]   a,
  input  logic [LIMB_W*WORDS-1:0]   b,
  input  logic                      sub,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LIMB_W*WORDS-1:0]   sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Producer holds in_valid and operands until in_ready; the result is held
  // on sum/cout/ovf with out_valid high until out_ready.
  localparam int W     = LIMB_W * WORDS;
  localparam int IDX_W = idx_width(WORDS);

  seq_state_e        state, state_d;
  logic [IDX_W-1:0]  idx;
  logic [W-1:0]      a_r, b_r, sum_r;
  logic              carry_r, cout_r, ovf_r;

  logic [LIMB_W-1:0] cla_a, cla_b, cla_sum;
  logic              cla_cout;
  logic              last;

  assign cla_a = a_r[int'(idx)*LIMB_W +: LIMB_W];
  assign cla_b = b_r[int'(idx)*LIMB_W +: LIMB_W];
  assign last  = (idx == IDX_W'(WORDS - 1));

  CLA_16bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_r),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Subtraction is A + ~B + 1, so the inverted B and forced carry are
          // stored once and RUN never needs to know the operation.
          a_r     <= a;
          b_r     <= sub ? ~b : b;
          carry_r <= sub ? 1'b1 : cin;
          idx     <= '0;
        end
        RUN: begin
          sum_r[int'(idx)*LIMB_W +: LIMB_W] <= cla_sum;
          carry_r <= cla_cout;
          idx     <= last ? '0 : idx + 1'b1;
          if (last) begin
            cout_r <= cla_cout;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (cla_sum[LIMB_W-1] != a_r[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Scoreboard bench for cla_multiword_seq: directed corner cases, backpressure,
// mid-operation reset and randomized traffic against a wide-arithmetic model.
module tb_cla_multiword_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk, rst_n;
  logic         in_valid, in_ready, sub, cin;
  logic [W-1:0] a, b, sum;
  logic         out_valid, out_ready, cout, ovf, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic         bp_en = 1'b0;

  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [W+1:0] act, input logic [W+1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on widened operands.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic s, input logic c);
    logic [W:0]   ext;
    logic [W+1:0] sr;
    logic [W-1:0] r;
    logic         co, ov;
    if (s) begin
      r  = av - bv;
      co = (av >= bv);
      sr = {av[W-1], av[W-1], av} - {bv[W-1], bv[W-1], bv};
    end else begin
      ext = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, c};
      r   = ext[W-1:0];
      co  = ext[W];
      sr  = {av[W-1], av[W-1], av} + {bv[W-1], bv[W-1], bv} + {{(W+1){1'b0}}, c};
    end
    ov = (sr[W] != sr[W-1]);
    return {r, co, ov};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*16 +: 16] = 16'($urandom_range(0, 65535));
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s, input logic c, output int waits);
    @(negedge clk);
    a = av; b = bv; sub = s; cin = c; in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", '0, '1);
    end else begin
      exp_q.push_back(model(av, bv, s, c));
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", (W+2)'(exp_q.size()), '0);
  endtask

  // ---------------- backpressure generator ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1 if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         prev_ov, hold;
    logic [W+1:0] held, e;
    int           lat;
    prev_ov = 1'b0; hold = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        hold    = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (acc_q.size() == 0) chk("latency_no_accept", '1, '0);
          else begin
            lat = cyc - acc_q.pop_front();
            chk("latency", (W+2)'(lat), (W+2)'(WORDS + 1));
          end
        end
        if (hold && out_valid) chk("hold_stable", {sum, cout, ovf}, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_result", {sum, cout, ovf}, '0);
          else begin
            e = exp_q.pop_front();
            chk("result", {sum, cout, ovf}, e);
          end
          hold = 1'b0;
        end else if (out_valid) begin
          hold = 1'b1;
          held = {sum, cout, ovf};
        end else begin
          hold = 1'b0;
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] ones, minv, maxv, one, va, vb;
    int           w;
    ones = '1;
    minv = '0; minv[W-1] = 1'b1;
    maxv = ~minv;
    one  = '0; one[0] = 1'b1;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    #3;
    chk("rst_out_valid", (W+2)'(out_valid), '0);
    chk("rst_in_ready",  (W+2)'(in_ready),  (W+2)'(1));
    chk("rst_busy",      (W+2)'(busy),      '0);
    chk("rst_result",    {sum, cout, ovf},  '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases
    va = '0; va[15:0] = 16'hFFFF;
    issue(va, one, 1'b0, 1'b0, w);
    issue(ones, one, 1'b0, 1'b0, w);
    issue(ones, '0, 1'b0, 1'b1, w);
    issue(W'(5), W'(7), 1'b1, 1'b1, w);
    issue(W'(7), W'(5), 1'b1, 1'b0, w);
    issue(maxv, one, 1'b0, 1'b0, w);
    issue(minv, one, 1'b1, 1'b0, w);
    drain();

    // Backpressure: result held 10 cycles while a new request waits
    set_ready(1'b0);
    issue(W'(64'h0123_4567_89AB_CDEF), W'(64'h1111_0000_FFFF_0001), 1'b0, 1'b1, w);
    w = 0;
    while (!out_valid && w < 50) begin @(negedge clk); w++; end
    chk("bp_out_valid", (W+2)'(out_valid), (W+2)'(1));
    va = W'(64'hDEAD_BEEF_0000_8000); vb = W'(64'hCAFE_F00D_8000_8000);
    a = va; b = vb; sub = 1'b1; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", (W+2)'(in_ready), '0);
    end
    set_ready(1'b1);
    issue(va, vb, 1'b1, 1'b0, w);
    chk("bp_accept_next_edge", (W+2)'(w), (W+2)'(1));
    drain();

    // Reset in the middle of RUN
    issue(ones, ones, 1'b0, 1'b1, w);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk("midrst_out_valid", (W+2)'(out_valid), '0);
    chk("midrst_busy",      (W+2)'(busy),      '0);
    chk("midrst_in_ready",  (W+2)'(in_ready),  (W+2)'(1));
    chk("midrst_result",    {sum, cout, ovf},  '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    issue(W'(64'h1234_5678_9ABC_DEF0), W'(64'h1111_1111_1111_1111), 1'b0, 1'b0, w);
    drain();

    // Randomized traffic with random consumer backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       va = ones;
        1:       va = minv;
        2:       va = maxv;
        default: va = rnd_word();
      endcase
      case ($urandom_range(0, 3))
        0:       vb = one;
        1:       vb = va;
        default: vb = rnd_word();
      endcase
      issue(va, vb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
    end
    bp_en = 1'b0;
    set_ready(1'b1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
